i2c_mst_ctrl_byte: RTL and testbench
====================================

Name: i2c_mst_ctrl_byte

Overview:
Byte-level sequencer for the I2C master bit controller. It turns host byte requests (start, write, read, stop) into the ordered stream of bit-controller commands (`I2C_CMD_*` from i2c_master_defines.v). It owns the 8-bit shift register, the bit counter and ACK handling, and returns one completion pulse per host request. It sits between the register/host interface and the bit controller.

Parameters:
BYTE_W, 8, bits per data transfer; only 8 is I2C-legal, other values are for bench use only.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  generate START before the data phase
stop  in  1  generate STOP after the data phase
read  in  1  read one byte
write  in  1  write one byte
ack_in  in  1  ACK bit the master drives after a read (0 = ACK, 1 = NACK)
din  in  BYTE_W  byte to transmit
cmd_ack  out  1  one-cycle pulse: request complete or aborted
ack_out  out  1  ACK bit sampled from the slave after a write
dout  out  BYTE_W  received byte
busy  out  1  high whenever state != ST_IDLE
al  out  1  one-cycle pulse: arbitration lost
rx_rd  in  1  host has consumed dout (used only with the optional feature)
bit_cmd  out  4  command to the bit controller (registered)
bit_cmd_ack  in  1  bit controller phase-complete strobe
bit_din  out  1  SDA value for a bit-controller WRITE (registered)
bit_dout  in  1  SDA value captured by the bit controller
bit_al  in  1  arbitration lost from the bit controller

Behaviour:
- Reset (sync, rst=1): state ST_IDLE, bit_cmd=`I2C_CMD_NOP`, bit_din=1, cmd_ack=0, ack_out=0, al=0, dout=0, shift reg=0, bit counter=0, busy=0. Reset overrides every other input, including a transfer in progress.
- States: ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP, plus ST_HOLD (optional feature only).
- Issue rule: in ST_IDLE, go = start|stop|read|write, and cmd_ack is not high in the same cycle. Priority is start > read > write > stop.
- The host holds the request flags and din stable from assertion until cmd_ack.
- Latency: bit_cmd changes on the clock edge after go is sampled (1 cycle).
- bit_cmd and state advance only on bit_cmd_ack, at the same edge on which the bit controller returns to idle, so there is no idle gap between phases.
- bit_cmd returns to NOP on the edge that completes the request.
- ST_START: issue START. On bit_cmd_ack, go to the first match of: read → ST_READ; write → ST_WRITE; stop → ST_STOP; none → done.
- Entering ST_WRITE: shift reg ← din, counter ← BYTE_W-1, bit_cmd=WRITE, bit_din=sr MSB.
  - On each bit_cmd_ack: shift left and decrement the counter.
  - On the ack with counter==0: go to ST_ACK with bit_cmd=READ.
- Entering ST_READ: counter ← BYTE_W-1, bit_cmd=READ.
  - On each bit_cmd_ack: sr ← {sr[BYTE_W-2:0], bit_dout}.
  - On the ack with counter==0: dout ← the completed byte; go to ST_ACK with bit_cmd=WRITE and bit_din=ack_in.
- ST_ACK: on bit_cmd_ack, ack_out ← bit_dout if the data phase was a write (ack_out is unchanged for a read). Then go to ST_STOP if stop, else done.
- ST_STOP: issue STOP; bit_cmd_ack → done.
- done: cmd_ack=1 for exactly one cycle, state ST_IDLE.
- Arbitration: bit_al=1 in any state → next edge state ST_IDLE, bit_cmd=NOP, bit_din=1, and al=1 and cmd_ack=1 for one cycle. dout and ack_out are unchanged. bit_al takes priority over a simultaneous bit_cmd_ack.
- bit_cmd_ack in ST_IDLE is ignored.

Optional Feature:
- Macro: I2C_MST_RX_HOLD_EN.
- With the macro:
  - rx_full is set when a read request completes and cleared by rx_rd; rx_rd wins a simultaneous set.
  - If a read data phase is about to start while rx_full=1 (from ST_IDLE or ST_START), the block enters ST_HOLD and bit_cmd=`I2C_CMD_WAIT` (SCL held low).
  - On the cycle after rx_full clears, bit_cmd=READ and ST_READ is entered.
  - bit_al in ST_HOLD aborts as above.
- Without the macro: there is no rx_full and no ST_HOLD, rx_rd is ignored, and dout is overwritten by each read.

Test Plan:
1. din=0xA5, start=write=1, bit_dout=0 at the ACK phase → bit_cmd sequence START, 8×WRITE with bit_din 1,0,1,0,0,1,0,1, then READ; ack_out=0; exactly one cmd_ack; busy low afterwards.
2. read=stop=1, ack_in=1, slave bits give 0x3C → dout=0x3C, ACK phase is WRITE with bit_din=1, then STOP, then one cmd_ack.
3. bit_al=1 during the 4th write bit → next cycle state ST_IDLE, bit_cmd=NOP, al and cmd_ack each pulse once, busy=0.
4. stop=1 only → a single STOP, then cmd_ack; no WRITE/READ issued.
5. rst=1 during read bit 3 → next cycle all outputs at reset values; a following write of 0x01 completes normally.
6. (I2C_MST_RX_HOLD_EN) two back-to-back reads with no rx_rd → WAIT held after the first; rx_rd after 50 cycles → READ issued on the next cycle and the second byte received.

Source files
------------

// File: rtl/i2c_mst_ctrl_byte_if.sv
// Host-side request/response bundle for the I2C byte sequencer.
// The master modport drives requests; the slave modport is the sequencer itself.
interface i2c_mst_ctrl_byte_if #(
    parameter int BYTE_W = 8
);
    logic              start;
    logic              stop;
    logic              read;
    logic              write;
    logic              ack_in;
    logic              rx_rd;
    logic [BYTE_W-1:0] din;
    logic              cmd_ack;
    logic              ack_out;
    logic [BYTE_W-1:0] dout;
    logic              busy;
    logic              al;

    modport master (
        output start, stop, read, write, ack_in, rx_rd, din,
        input  cmd_ack, ack_out, dout, busy, al
    );

    modport slave (
        input  start, stop, read, write, ack_in, rx_rd, din,
        output cmd_ack, ack_out, dout, busy, al
    );
endinterface

// File: rtl/i2c_mst_ctrl_byte.sv
// Byte sequencer: turns host start/write/read/stop requests into bit-controller commands.
// Optional receive hold (SCL stretched while dout is unread): define I2C_MST_RX_HOLD_EN.
`ifndef I2C_CMD_NOP
`define I2C_CMD_NOP   4'b0000
`define I2C_CMD_START 4'b0001
`define I2C_CMD_STOP  4'b0010
`define I2C_CMD_WRITE 4'b0100
`define I2C_CMD_READ  4'b1000
`define I2C_CMD_WAIT  4'b0011
`endif

module i2c_mst_ctrl_byte #(
    parameter int BYTE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    i2c_mst_ctrl_byte_if.slave  host,
    output logic [3:0]          bit_cmd,
    input  logic                bit_cmd_ack,
    output logic                bit_din,
    input  logic                bit_dout,
    input  logic                bit_al
);
    localparam int CW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
`ifdef I2C_MST_RX_HOLD_EN
        , ST_HOLD
`endif
    } state_t;

    state_t            state;
    logic [BYTE_W-1:0] sr;
    logic [BYTE_W-1:0] dout_r;
    logic [CW-1:0]     cnt;
    logic              cmd_ack_r;
    logic              ack_out_r;
    logic              al_r;
    logic              req_done;
    logic              phase_go;

`ifdef I2C_MST_RX_HOLD_EN
    logic              rx_full;
`else
    logic              unused_rx_rd;
    assign unused_rx_rd = host.rx_rd;
`endif

    assign host.cmd_ack = cmd_ack_r;
    assign host.ack_out = ack_out_r;
    assign host.dout    = dout_r;
    assign host.al      = al_r;
    assign host.busy    = (state != ST_IDLE);

    // req_done: last phase acknowledged; phase_go: choose the data/stop phase
    always_comb begin
        req_done = 1'b0;
        phase_go = 1'b0;
        if (!bit_al) begin
            req_done = bit_cmd_ack &&
                       ((state == ST_START && !(host.read || host.write || host.stop)) ||
                        (state == ST_ACK && !host.stop) ||
                        (state == ST_STOP));
            phase_go = (state == ST_IDLE && !cmd_ack_r && !host.start &&
                        (host.read || host.write || host.stop)) ||
                       (state == ST_START && bit_cmd_ack);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cmd   <= `I2C_CMD_NOP;
            bit_din   <= 1'b1;
            cmd_ack_r <= 1'b0;
            ack_out_r <= 1'b0;
            al_r      <= 1'b0;
            dout_r    <= '0;
            sr        <= '0;
            cnt       <= '0;
`ifdef I2C_MST_RX_HOLD_EN
            rx_full   <= 1'b0;
`endif
        end else begin
            cmd_ack_r <= 1'b0;
            al_r      <= 1'b0;
            if (!bit_al && state == ST_ACK && bit_cmd_ack && !host.read)
                ack_out_r <= bit_dout;

            if (bit_al) begin
                state     <= ST_IDLE;
                bit_cmd   <= `I2C_CMD_NOP;
                bit_din   <= 1'b1;
                al_r      <= 1'b1;
                cmd_ack_r <= 1'b1;
            end else if (req_done) begin
                state     <= ST_IDLE;
                bit_cmd   <= `I2C_CMD_NOP;
                bit_din   <= 1'b1;
                cmd_ack_r <= 1'b1;
`ifdef I2C_MST_RX_HOLD_EN
                if (host.read)
                    rx_full <= 1'b1;
`endif
            end else if (phase_go) begin
                if (host.read) begin
`ifdef I2C_MST_RX_HOLD_EN
                    if (rx_full) begin
                        state   <= ST_HOLD;
                        bit_cmd <= `I2C_CMD_WAIT;
                    end else
`endif
                    begin
                        state   <= ST_READ;
                        cnt     <= CW'(BYTE_W - 1);
                        bit_cmd <= `I2C_CMD_READ;
                        bit_din <= 1'b1;
                    end
                end else if (host.write) begin
                    state   <= ST_WRITE;
                    sr      <= host.din;
                    cnt     <= CW'(BYTE_W - 1);
                    bit_cmd <= `I2C_CMD_WRITE;
                    bit_din <= host.din[BYTE_W-1];
                end else begin
                    state   <= ST_STOP;
                    bit_cmd <= `I2C_CMD_STOP;
                    bit_din <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (host.start && !cmd_ack_r) begin
                            state   <= ST_START;
                            bit_cmd <= `I2C_CMD_START;
                        end
                    end
                    ST_WRITE: begin
                        if (bit_cmd_ack) begin
                            sr  <= {sr[BYTE_W-2:0], 1'b0};
                            cnt <= cnt - 1'b1;
                            if (cnt == '0) begin
                                state   <= ST_ACK;
                                bit_cmd <= `I2C_CMD_READ;
                                bit_din <= 1'b1;
                            end else begin
                                bit_din <= sr[BYTE_W-2];
                            end
                        end
                    end
                    ST_READ: begin
                        if (bit_cmd_ack) begin
                            sr  <= {sr[BYTE_W-2:0], bit_dout};
                            cnt <= cnt - 1'b1;
                            if (cnt == '0) begin
                                dout_r  <= {sr[BYTE_W-2:0], bit_dout};
                                state   <= ST_ACK;
                                bit_cmd <= `I2C_CMD_WRITE;
                                bit_din <= host.ack_in;
                            end
                        end
                    end
                    ST_ACK: begin
                        // completion without STOP is taken by req_done above
                        if (bit_cmd_ack) begin
                            state   <= ST_STOP;
                            bit_cmd <= `I2C_CMD_STOP;
                            bit_din <= 1'b1;
                        end
                    end
`ifdef I2C_MST_RX_HOLD_EN
                    ST_HOLD: begin
                        if (!rx_full) begin
                            state   <= ST_READ;
                            cnt     <= CW'(BYTE_W - 1);
                            bit_cmd <= `I2C_CMD_READ;
                            bit_din <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
`ifdef I2C_MST_RX_HOLD_EN
            if (host.rx_rd)
                rx_full <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_i2c_mst_ctrl_byte.sv
// Bench for i2c_mst_ctrl_byte: bit-controller responder plus a phase-list reference model.
module tb_i2c_mst_ctrl_byte;
    localparam int W = 8;
    localparam logic [3:0] C_NOP   = 4'b0000;
    localparam logic [3:0] C_START = 4'b0001;
    localparam logic [3:0] C_STOP  = 4'b0010;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_READ  = 4'b1000;
    localparam logic [3:0] C_WAIT  = 4'b0011;

    typedef struct packed {
        logic [3:0] cmd;
        logic       din;
    } phase_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bit_cmd;
    logic       bit_cmd_ack = 1'b0;
    logic       bit_din;
    logic       bit_dout = 1'b1;
    logic       bit_al = 1'b0;

    i2c_mst_ctrl_byte_if #(.BYTE_W(W)) hif ();

    i2c_mst_ctrl_byte #(.BYTE_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hif),
        .bit_cmd     (bit_cmd),
        .bit_cmd_ack (bit_cmd_ack),
        .bit_din     (bit_din),
        .bit_dout    (bit_dout),
        .bit_al      (bit_al)
    );

    always #5 clk = ~clk;

    phase_t     log_q[$];
    phase_t     exp_q[$];
    logic       slave_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         ack_cnt = 0;
    int         al_cnt = 0;
    int         lat_max = 3;
    logic [7:0] exp_dout = 8'h00;
    logic       exp_ack_out = 1'b0;

    // Bit-controller model: logs each phase, acks after a random latency.
    initial begin
        logic active;
        int   wcnt;
        active = 1'b0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bit_cmd_ack) begin
                bit_cmd_ack = 1'b0;
                active = 1'b0;
            end
            if (bit_cmd == C_NOP || bit_cmd == C_WAIT || rst) begin
                active = 1'b0;
                bit_cmd_ack = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                wcnt = $urandom_range(lat_max, (lat_max == 3) ? 3 : 0);
                log_q.push_back({bit_cmd, bit_din});
                if (bit_cmd == C_READ)
                    bit_dout = (slave_q.size() > 0) ? slave_q.pop_front() : 1'b1;
            end
            if (active) begin
                if (wcnt == 0) bit_cmd_ack = 1'b1;
                else wcnt--;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (hif.cmd_ack) ack_cnt++;
        if (hif.al) al_cnt++;
    endtask

    task automatic drop_flags();
        hif.start = 1'b0;
        hif.stop  = 1'b0;
        hif.read  = 1'b0;
        hif.write = 1'b0;
    endtask

    // Expected phase list built from the request, not from the sequencer's states.
    task automatic launch(input logic s, input logic p, input logic r, input logic w,
                          input logic [7:0] d, input logic ai,
                          input logic [7:0] sb, input logic ab);
        exp_q.delete();
        slave_q.delete();
        log_q.delete();
        ack_cnt = 0;
        al_cnt = 0;
        if (s) exp_q.push_back({C_START, 1'b1});
        if (r) begin
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back({C_READ, 1'b1});
                slave_q.push_back(sb[i]);
            end
            exp_q.push_back({C_WRITE, ai});
            exp_dout = sb;
        end else if (w) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back({C_WRITE, d[i]});
            exp_q.push_back({C_READ, 1'b1});
            slave_q.push_back(ab);
            exp_ack_out = ab;
        end
        if (p) exp_q.push_back({C_STOP, 1'b1});
        hif.din = d;
        hif.ack_in = ai;
        hif.start = s;
        hif.stop = p;
        hif.read = r;
        hif.write = w;
    endtask

    task automatic finish_req(input string tag);
        int n = 0;
        while (!hif.cmd_ack && n < 400) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 400), 32'd1);
        drop_flags();
        repeat (3) step();
        chk({tag, "_cmd_ack_cnt"}, 32'(ack_cnt), 32'd1);
        chk({tag, "_busy"}, 32'(hif.busy), 32'd0);
        chk({tag, "_dout"}, 32'(hif.dout), 32'(exp_dout));
        chk({tag, "_ack_out"}, 32'(hif.ack_out), 32'(exp_ack_out));
        chk({tag, "_nphases"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("%s_cmd%0d", tag, i), 32'(log_q[i].cmd), 32'(exp_q[i].cmd));
            if (exp_q[i].cmd == C_WRITE)
                chk($sformatf("%s_din%0d", tag, i), 32'(log_q[i].din), 32'(exp_q[i].din));
        end
    endtask

    task automatic do_xfer(input string tag, input logic s, input logic p, input logic r,
                           input logic w, input logic [7:0] d, input logic ai,
                           input logic [7:0] sb, input logic ab);
        launch(s, p, r, w, d, ai, sb, ab);
        step();
        chk({tag, "_first_cmd"}, 32'(bit_cmd), 32'(exp_q[0].cmd));
        finish_req(tag);
`ifdef I2C_MST_RX_HOLD_EN
        if (r) begin
            hif.rx_rd = 1'b1;
            step();
            hif.rx_rd = 1'b0;
        end
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bit_cmd"}, 32'(bit_cmd), 32'(C_NOP));
        chk({tag, "_bit_din"}, 32'(bit_din), 32'd1);
        chk({tag, "_cmd_ack"}, 32'(hif.cmd_ack), 32'd0);
        chk({tag, "_ack_out"}, 32'(hif.ack_out), 32'd0);
        chk({tag, "_al"}, 32'(hif.al), 32'd0);
        chk({tag, "_dout"}, 32'(hif.dout), 32'd0);
        chk({tag, "_busy"}, 32'(hif.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] old_dout;
        logic       old_ack;
        int         n;
        drop_flags();
        hif.din = 8'h00;
        hif.ack_in = 1'b0;
        hif.rx_rd = 1'b0;
        repeat (3) step();
        chk_reset_vals("rst");
        rst = 1'b0;
        step();

        do_xfer("t1_write", 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
        do_xfer("t2_read", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0);

        // Arbitration lost during the 4th write bit
        lat_max = 3;
        old_dout = exp_dout;
        old_ack = exp_ack_out;
        launch(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        exp_dout = old_dout;
        exp_ack_out = old_ack;
        n = 0;
        while (log_q.size() < 5 && n < 200) begin
            step();
            n++;
        end
        chk("t3_reach_bit4", 32'(n < 200), 32'd1);
        bit_al = 1'b1;
        step();
        bit_al = 1'b0;
        drop_flags();
        chk("t3_busy", 32'(hif.busy), 32'd0);
        chk("t3_bit_cmd", 32'(bit_cmd), 32'(C_NOP));
        chk("t3_bit_din", 32'(bit_din), 32'd1);
        chk("t3_al", 32'(hif.al), 32'd1);
        chk("t3_cmd_ack", 32'(hif.cmd_ack), 32'd1);
        chk("t3_dout", 32'(hif.dout), 32'(exp_dout));
        chk("t3_ack_out", 32'(hif.ack_out), 32'(exp_ack_out));
        repeat (3) step();
        chk("t3_al_cnt", 32'(al_cnt), 32'd1);
        chk("t3_ack_cnt", 32'(ack_cnt), 32'd1);
        lat_max = 2;

        do_xfer("t4_stop", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Reset in the middle of read bit 3
        launch(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'(($urandom)), 1'b0);
        n = 0;
        while (log_q.size() < 4 && n < 200) begin
            step();
            n++;
        end
        chk("t5_reach_bit3", 32'(n < 200), 32'd1);
        rst = 1'b1;
        drop_flags();
        step();
        rst = 1'b0;
        chk_reset_vals("t5_rst");
        exp_dout = 8'h00;
        exp_ack_out = 1'b0;
        step();
        do_xfer("t5_write", 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0);

`ifdef I2C_MST_RX_HOLD_EN
        launch(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h96, 1'b0);
        finish_req("t6_rd1");
        launch(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h4B, 1'b0);
        step();
        chk("t6_wait0", 32'(bit_cmd), 32'(C_WAIT));
        repeat (49) step();
        chk("t6_wait50", 32'(bit_cmd), 32'(C_WAIT));
        chk("t6_busy", 32'(hif.busy), 32'd1);
        hif.rx_rd = 1'b1;
        step();
        hif.rx_rd = 1'b0;
        chk("t6_wait_rxrd", 32'(bit_cmd), 32'(C_WAIT));
        step();
        chk("t6_read", 32'(bit_cmd), 32'(C_READ));
        finish_req("t6_rd2");
        hif.rx_rd = 1'b1;
        step();
        hif.rx_rd = 1'b0;
`endif

        for (int k = 0; k < 24; k++) begin
            logic [3:0] f;
            f = 4'($urandom_range(1, 15));
            do_xfer($sformatf("rnd%0d", k), f[0], f[1], f[2], f[3],
                    8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
